sine_rom_reader: RTL
====================

# sine_rom_reader

Phase-accumulator address generator that reads the 128-entry sine lookup ROM and turns it into a paced, valid-flagged sample stream. It drives the ROM address and captures the registered ROM data, so it must account for the ROM's one-cycle read latency. Start and stop are commanded by pulses, and it stops only at a cycle boundary so the output ends near mid-scale. It sits between the control registers and the DAC/PWM output stage.

## Interface
- ACC_W, 16, phase accumulator width (≥ 8)
- IDX_W, 7, table index bits taken from accumulator MSBs (128 entries)
- ADDR_W, 8, ROM address width; upper bits above IDX_W driven 0
- DATA_W, 16, sample width
- MID, 800, mid-scale code (ROM reset value)

Ports:
- clk  in  1  system clock, all logic on rising edge
- nreset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begin playback
- stop  in  1  one-cycle pulse, request stop at next wrap
- tuning_word  in  ACC_W  phase increment, latched on accepted start
- sample_div  in  16  sample period minus 1, in clk cycles, latched on accepted start
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr is sampled
- sample  out  DATA_W  captured sample, held between updates
- sample_valid  out  1  one-cycle pulse per new sample
- cycle_done  out  1  one-cycle pulse when the accumulator carries out
- busy  out  1  high in RUN, FINISH, FLUSH

## Operation
- States: IDLE, RUN, FINISH, FLUSH.
- IDLE:
  - On `start` with `stop` low: latch `tw`/`div`, clear phase and div_cnt, go to RUN.
  - `stop` in IDLE is ignored. Simultaneous `start` and `stop` in IDLE: stop wins, stay IDLE.
- Tick: div_cnt counts 0..div and wraps. A tick occurs in RUN/FINISH when div_cnt == div.
- On each tick:
  - `rom_addr <= {0, phase[ACC_W-1 -: IDX_W]}`.
  - `phase <= phase + tw` (mod 2^ACC_W).
  - Push a 1 into the 2-stage issue pipe.
  - A carry-out sets `cycle_done` the next cycle.
- Capture: when pipe stage 2 is set, `sample <= rom_data` and `sample_valid` pulses.
- RUN:
  - `stop` moves to FINISH. If tw == 0, go directly to FLUSH instead.
  - `start` is ignored.
- FINISH:
  - Keep ticking.
  - On the tick whose addition carries out, issue that address, then go to FLUSH.
- FLUSH: no new issues. Wait until the issue pipe is empty (2 cycles), then go to IDLE with `rom_addr <= 0`.
- `sample` holds the last value after stop.

## Timing
- Reset values: `rom_addr` = 0, `sample` = MID, `sample_valid` = 0, `cycle_done` = 0, `busy` = 0, state IDLE, phase = 0.
- Latency: tick in cycle T → `rom_addr` valid T+1 → ROM data T+2 → `sample_valid` high in T+3.
- With div = 0, samples arrive every cycle, fully pipelined.
- `start` accepted at edge E: the first tick is the cycle after E, so the first `sample_valid` is 3 cycles later.
- `busy` rises the cycle after an accepted start. It falls the cycle after the last `sample_valid` of a stop sequence.
- `nreset` low mid-operation: all state and outputs return to reset values at that edge, and the pipe is discarded. No sample is emitted for in-flight reads.

## Structure
- Shared package `dds_pkg`:
  - State enum.
  - IDX_W, MID, ROM_LATENCY = 1, ISSUE_PIPE = ROM_LATENCY + 1.
- One sub-module `tick_divider`: holds the latched div, counts, and emits `tick`. It clears on start and reset.
- The FSM, accumulator and capture pipe stay in the top module.

## Test plan
- Bench uses a cycle-accurate ROM model (registered, default MID).
1. Reset, start with tw = 0x0200, div = 0 → `rom_addr` 0,1,2…127,0 on consecutive cycles; samples 800,831,863,894…; first `sample_valid` 3 cycles after the start edge; `cycle_done` pulse after index 127.
2. tw = 0x0200, div = 3 → `sample_valid` exactly every 4 cycles; 8 samples in 32 cycles after the first; values 800,831,863…
3. tw = 0x4000, div = 0 → addresses 0,32,64,96,0…; samples 800,1440,800,160 repeating; `cycle_done` every 4 samples.
4. Stop pulse while `rom_addr` = 40 (tw = 0x0200) → samples continue through index 127 (last `sample` 769); no index 0 is issued; `busy` falls one cycle after the last `sample_valid`; exactly 1 `cycle_done`.
5. `nreset` low mid-RUN for 1 cycle → next cycle `sample` = 800, `rom_addr` = 0, `busy` = 0, no stray `sample_valid`; a new start restarts from index 0.
6. Start and stop together in IDLE → stays IDLE, `busy` = 0. Start with tw = 0, then stop → continuous 800 samples, then FLUSH → IDLE within 3 cycles.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the sine ROM reader: FSM states and table/pipe sizing.
package dds_pkg;

   localparam int IDX_W       = 7;
   localparam int MID         = 800;
   localparam int ROM_LATENCY = 1;
   // One stage for the address register, plus one per ROM read cycle.
   localparam int ISSUE_PIPE  = ROM_LATENCY + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH,
      FLUSH
   } state_t;

endpackage

// File: rtl/sine_rom_reader_tick_divider.sv
// Sample-rate divider: latches the period on start and pulses tick once per
// (div + 1) enabled cycles, on the cycle where the count reaches div.
module tick_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_in,
   output logic             tick
);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] cnt;

   assign tick = enable && (cnt == div);

   // Latch the period on start, then count 0..div and wrap while enabled.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         // NOTE: registers use <= so every flop samples pre-edge values, which is
         // what makes the divider, FSM and pipe update together without races.
         div <= '0;
         cnt <= '0;
      end else if (clear) begin
         div <= div_in;
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == div) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sine_rom_reader.sv
// Phase-accumulator reader for the 128-entry sine ROM. Issues a ROM address on
// every divider tick, tracks the ROM's read latency with a small issue pipe and
// captures the returned data as a valid-flagged sample. A stop request lets the
// current waveform cycle complete so playback ends near mid-scale.
module sine_rom_reader
   import dds_pkg::state_t;
   import dds_pkg::ISSUE_PIPE;
#(
   parameter int ACC_W  = 16,
   parameter int IDX_W  = dds_pkg::IDX_W,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int MID    = dds_pkg::MID
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic              stop,
   input  logic [ACC_W-1:0]  tuning_word,
   input  logic [15:0]       sample_div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              cycle_done,
   output logic              busy
);

   state_t                 state;
   logic [ACC_W-1:0]       phase;
   logic [ACC_W-1:0]       tw;
   logic [ISSUE_PIPE-1:0]  pipe;
   logic [ACC_W:0]         phase_sum;
   logic                   carry;
   logic [IDX_W-1:0]       table_idx;
   logic                   start_ok;
   logic                   active;
   logic                   tick;

   assign phase_sum = {1'b0, phase} + {1'b0, tw};
   assign carry     = phase_sum[ACC_W];
   assign table_idx = phase[ACC_W-1 -: IDX_W];
   // Simultaneous start and stop in IDLE is treated as a stop.
   assign start_ok  = (state == dds_pkg::IDLE) && start && !stop;
   assign active    = (state == dds_pkg::RUN) || (state == dds_pkg::FINISH);

   tick_divider #(
      .DIV_W (16)
   ) u_tick_divider (
      .clk    (clk),
      .nreset (nreset),
      .clear  (start_ok),
      .enable (active),
      .div_in (sample_div),
      .tick   (tick)
   );

   // Control FSM, phase accumulator, issue pipe and sample capture.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state        <= dds_pkg::IDLE;
         phase        <= '0;
         tw           <= '0;
         pipe         <= '0;
         rom_addr     <= '0;
         sample       <= DATA_W'(MID);
         sample_valid <= 1'b0;
         cycle_done   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         cycle_done   <= 1'b0;
         // Each tick marks an in-flight read; it reaches the top stage exactly
         // when the ROM presents the data for that address.
         pipe         <= {pipe[ISSUE_PIPE-2:0], tick};

         if (pipe[ISSUE_PIPE-1]) begin
            sample       <= rom_data;
            sample_valid <= 1'b1;
         end

         if (tick) begin
            rom_addr   <= ADDR_W'(table_idx);
            phase      <= phase_sum[ACC_W-1:0];
            cycle_done <= carry;
         end

         case (state)
            dds_pkg::IDLE: begin
               if (start_ok) begin
                  tw    <= tuning_word;
                  phase <= '0;
                  busy  <= 1'b1;
                  state <= dds_pkg::RUN;
               end
            end
            dds_pkg::RUN: begin
               if (stop) begin
                  // A zero increment never wraps, and a tick that wraps in the
                  // stop cycle already completes the waveform.
                  if ((tw == '0) || (tick && carry)) state <= dds_pkg::FLUSH;
                  else                               state <= dds_pkg::FINISH;
               end
            end
            dds_pkg::FINISH: begin
               if (tick && carry) state <= dds_pkg::FLUSH;
            end
            dds_pkg::FLUSH: begin
               if (pipe == '0) begin
                  rom_addr <= '0;
                  busy     <= 1'b0;
                  state    <= dds_pkg::IDLE;
               end
            end
            default: state <= dds_pkg::IDLE;
         endcase
      end
   end

endmodule
